instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Fetch-side initiator for the combinational instruction memory: drives Address, samples Instruction in the same cycle, and buffers fetched words in a small prefetch FIFO.
- Presents instructions to the decode stage via a valid/ready handshake.
- Decode or execute can redirect the fetch stream (branch, jal, jr) at any time, which flushes the FIFO.

Parameters:
- RESET_PC, 32'h00000000, fetch address loaded on reset.
- DEPTH, 2, prefetch FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Address  output  32  fetch address to instruction memory (equals FetchPC)
- Instruction  input  32  memory read data; combinational function of Address, valid in the same cycle
- Redirect  input  1  load Target as the new fetch address and flush the FIFO
- Target  input  32  redirect address
- IF_Ready  input  1  decode accepts the head entry this cycle
- IF_Valid  output  1  FIFO head holds a valid instruction
- IF_Instruction  output  32  head instruction word
- IF_PC  output  32  address of the head instruction
- IF_PCPlus4  output  32  IF_PC + 4, modulo 2^32
- AlignFault  output  1  misaligned redirect target seen (only with the optional feature; tied 0 otherwise)

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FetchPC = RESET_PC; FIFO empty; IF_Valid = 0.
  - IF_Instruction, IF_PC, IF_PCPlus4 = 0 while empty. AlignFault = 0.
- Reset asserted mid-operation discards all entries immediately.
- Address = FetchPC at all times, including during reset.
- Pop: occurs when IF_Valid && IF_Ready at a rising edge. The head advances.
- Push: occurs when no Redirect && (count < DEPTH || pop this cycle).
  - Writes {Instruction, FetchPC} at the tail.
  - FetchPC <= FetchPC + 4, wrapping at 2^32.
- Full with no pop: no push; FetchPC holds.
- Full with simultaneous pop: push and pop both occur; count unchanged.
- Empty: IF_Valid = 0. A push makes IF_Valid = 1 on the next cycle. There is no same-cycle bypass, so fetch-to-valid latency is 1 cycle.
- Redirect = 1:
  - Next cycle the FIFO is empty (count = 0) and FetchPC = Target.
  - No push this cycle; the Instruction sampled this cycle is discarded.
  - A pop in the same cycle completes; decode owns that word, and the flush still clears the remainder.
  - The first redirected instruction appears on IF_Valid 2 cycles after the Redirect edge.
- Back-to-back Redirects: the last one wins; no instructions are delivered in between.
- Steady state with IF_Ready held at 1: one instruction per cycle, addresses strictly sequential.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Outputs IF_Instruction, IF_PC and IF_PCPlus4 come from registered FIFO storage selected by the head pointer. No combinational path exists from Instruction to IF_*.
- Target low bits are not masked when the optional feature is absent.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - A Redirect with Target[1:0] != 0 sets AlignFault = 1 (sticky) and flushes the FIFO.
  - Fetch is then halted: no pushes, FetchPC = Target with the low 2 bits cleared.
  - AlignFault clears, and fetch resumes, on the next Redirect with an aligned Target; that Redirect behaves normally.
  - Only reset or an aligned Redirect clears AlignFault.
- When undefined:
  - AlignFault is tied 0.
  - Any Target is loaded unchanged; memory ignores Address[1:0].

Test Plan:
- Reset release, memory word0 = 0x20040004, word1 = 0x0C000003, IF_Ready = 1 -> IF_Valid rises 1 cycle after first edge; IF_PC = 0, then 4; IF_Instruction = 0x20040004, then 0x0C000003; IF_PCPlus4 = 4, then 8.
- IF_Ready = 0 for 6 cycles, DEPTH = 2 -> exactly 2 entries (PC 0, 4) buffered; Address frozen at 8; on IF_Ready = 1 PCs 0, 4, 8, 12 delivered on consecutive cycles without gaps.
- Redirect with Target = 0x0000000C while FIFO holds PC 4, 8 -> next cycle IF_Valid = 0 and Address = 0xC; following cycle IF_PC = 0xC; PC 8 is never delivered.
- Redirect and pop in the same cycle -> popped entry counted as accepted; FIFO empty afterwards; two Redirects on consecutive cycles (0x10, then 0x28) -> first delivered IF_PC = 0x28.
- FetchPC = 0xFFFFFFFC -> IF_PCPlus4 = 0; next fetch Address = 0.
- With FETCH_ALIGN_CHECK_EN, Redirect Target = 0x0000000E -> AlignFault = 1, IF_Valid stays 0 for 5+ cycles; Redirect Target = 0x10 -> AlignFault = 0, IF_PC = 0x10 two cycles later.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the combinational instruction memory and buffers words in a prefetch FIFO.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirect halts fetch and raises sticky AlignFault).
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Address,
    input  logic [31:0] Instruction,
    input  logic        Redirect,
    input  logic [31:0] Target,
    input  logic        IF_Ready,
    output logic        IF_Valid,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCPlus4,
    output logic        AlignFault
);

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C  = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   pc_mem_d [DEPTH];
    logic          empty_s, pop_s, push_s, halt_s;

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_fault_q, align_fault_d;
    assign halt_s     = align_fault_q;
    assign AlignFault = align_fault_q;
`else
    assign halt_s     = 1'b0;
    assign AlignFault = 1'b0;
`endif

    assign Address = fetch_pc_q;

    // Handshake qualifiers: a pop frees a slot for a push in the same cycle.
    always_comb begin
        empty_s = (count_q == {(PW + 1){1'b0}});
        pop_s   = !empty_s && IF_Ready;
        push_s  = !Redirect && !halt_s && ((count_q < DEPTH_C) || pop_s);
    end

    // Next-state logic for fetch PC, FIFO pointers, storage and fault flag.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            instr_mem_d[i] = instr_mem_q[i];
            pc_mem_d[i]    = pc_mem_q[i];
        end
`ifdef FETCH_ALIGN_CHECK_EN
        align_fault_d = align_fault_q;
`endif
        if (Redirect) begin
            // The word fetched this cycle is dropped; a concurrent pop has already been accepted.
            head_d     = {PW{1'b0}};
            tail_d     = {PW{1'b0}};
            count_d    = {(PW + 1){1'b0}};
            fetch_pc_d = Target;
`ifdef FETCH_ALIGN_CHECK_EN
            if (Target[1:0] != 2'b00) begin
                align_fault_d = 1'b1;
                fetch_pc_d    = {Target[31:2], 2'b00};
            end else begin
                align_fault_d = 1'b0;
            end
`endif
        end else begin
            if (push_s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (tail_q == PW'(i)) begin
                        instr_mem_d[i] = Instruction;
                        pc_mem_d[i]    = fetch_pc_q;
                    end else begin
                        instr_mem_d[i] = instr_mem_q[i];
                    end
                end
                tail_d     = tail_q + PTR_ONE;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + {{PW{1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{PW{1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset discards all buffered entries at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {(PW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= 32'h00000000;
                pc_mem_q[i]    <= 32'h00000000;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            align_fault_q <= 1'b0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= instr_mem_d[i];
                pc_mem_q[i]    <= pc_mem_d[i];
            end
`ifdef FETCH_ALIGN_CHECK_EN
            align_fault_q <= align_fault_d;
`endif
        end
    end

    // Head entry presentation; all-zero while the FIFO is empty.
    always_comb begin
        IF_Valid = !empty_s;
        if (!empty_s) begin
            IF_Instruction = instr_mem_q[head_q];
            IF_PC          = pc_mem_q[head_q];
            IF_PCPlus4     = pc_mem_q[head_q] + 32'd4;
        end else begin
            IF_Instruction = 32'h00000000;
            IF_PC          = 32'h00000000;
            IF_PCPlus4     = 32'h00000000;
        end
    end

endmodule
